vga_pmod_out: RTL and testbench

Parametrised VGA output stage sitting between the game/video core and the TinyTapeout pins (`uo_out`, `uio_out`, `uio_oe`). It takes wide per-channel colour plus HS/VS/DE and reduces the colour to the selected PMOD format: 12-bit dual PMOD, or 6-bit single TinyVGA PMOD. Reduction uses a 4x4 ordered (Bayer) dither with frame-rotated offsets. Mode changes are synchronised and committed only at a vertical-sync edge, so the pins never glitch mid-frame.

---
 rtl/vga_pmod_out.sv | 140 ++++++++++++++
 tb/tb_vga_pmod_out.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_pmod_out.sv
// rtl/vga_pmod_out.sv - VGA output stage: colour reduction with ordered dither and PMOD pin mapping.
// Two-stage pipeline; the pin map only switches on a vsync falling edge.
module vga_pmod_out #(
  parameter int IN_BITS = 6,
  parameter int DITHER  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [IN_BITS-1:0] r_in,
  input  logic [IN_BITS-1:0] g_in,
  input  logic [IN_BITS-1:0] b_in,
  input  logic               hs_in,
  input  logic               vs_in,
  input  logic               de_in,
  input  logic               mode_sel,
  output logic [7:0]         uo_out,
  output logic [7:0]         uio_out,
  output logic [7:0]         uio_oe
);

  logic [IN_BITS-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
  logic               hs_q, hs_d, vs_q, vs_d, de_q, de_d;
  logic [1:0]         col_q, col_d, row_q, row_d, frm_q, frm_d;
  logic               mode_meta_q, mode_meta_d, mode_sync_q, mode_sync_d;
  logic               mode_act_q, mode_act_d;
  logic [7:0]         uo_q, uo_d, uio_q, uio_d, oe_q, oe_d;
  logic               vs_fall, de_fall;
  logic [3:0]         thr, r_o, g_o, b_o;

  function automatic logic [3:0] bayer(input logic [1:0] row, input logic [1:0] idx);
    case ({row, idx})
      4'h0: bayer = 4'd0;
      4'h1: bayer = 4'd8;
      4'h2: bayer = 4'd2;
      4'h3: bayer = 4'd10;
      4'h4: bayer = 4'd12;
      4'h5: bayer = 4'd4;
      4'h6: bayer = 4'd14;
      4'h7: bayer = 4'd6;
      4'h8: bayer = 4'd3;
      4'h9: bayer = 4'd11;
      4'hA: bayer = 4'd1;
      4'hB: bayer = 4'd9;
      4'hC: bayer = 4'd15;
      4'hD: bayer = 4'd7;
      4'hE: bayer = 4'd13;
      default: bayer = 4'd5;
    endcase
  endfunction

  // The fraction is the bits below q, left-aligned: shifting {v,0000} keeps zero padding on the right.
  function automatic logic [3:0] reduce(input logic [IN_BITS-1:0] v, input logic m,
                                        input logic [3:0] t);
    logic [3:0] q;
    logic [3:0] f;
    logic       bump;
    if (m) begin
      q = {2'b00, 2'(v >> (IN_BITS - 2))};
      f = 4'({v, 4'b0000} >> (IN_BITS - 2));
    end else begin
      q = 4'(v >> (IN_BITS - 4));
      f = 4'({v, 4'b0000} >> (IN_BITS - 4));
    end
    bump = (DITHER != 0) && (f > t) && (q != (m ? 4'd3 : 4'd15));
    return q + {3'b000, bump};
  endfunction

  always_comb begin
    vs_fall     = ~vs_in & vs_q;
    de_fall     = ~de_in & de_q;
    r_d         = r_in;
    g_d         = g_in;
    b_d         = b_in;
    hs_d        = hs_in;
    vs_d        = vs_in;
    de_d        = de_in;
    col_d       = (de_in & de_q) ? col_q + 2'd1 : 2'd0;
    row_d       = ~vs_in ? 2'd0 : (de_fall ? row_q + 2'd1 : row_q);
    frm_d       = vs_fall ? frm_q + 2'd1 : frm_q;
    mode_meta_d = mode_sel;
    mode_sync_d = mode_meta_q;
    mode_act_d  = vs_fall ? mode_sync_q : mode_act_q;
  end

  always_comb begin
    thr = bayer(row_q, col_q + frm_q);
    r_o = de_q ? reduce(r_q, mode_act_q, thr) : 4'd0;
    g_o = de_q ? reduce(g_q, mode_act_q, thr) : 4'd0;
    b_o = de_q ? reduce(b_q, mode_act_q, thr) : 4'd0;
    uo_d  = {b_o, r_o};
    uio_d = {2'b00, vs_q, hs_q, g_o};
    oe_d  = 8'hFF;
    if (mode_act_q) begin
      uo_d  = {hs_q, b_o[0], g_o[0], r_o[0], vs_q, b_o[1], g_o[1], r_o[1]};
      uio_d = 8'h00;
      oe_d  = 8'h00;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q         <= '0;
      g_q         <= '0;
      b_q         <= '0;
      hs_q        <= 1'b1;
      vs_q        <= 1'b1;
      de_q        <= 1'b0;
      col_q       <= 2'd0;
      row_q       <= 2'd0;
      frm_q       <= 2'd0;
      mode_meta_q <= 1'b0;
      mode_sync_q <= 1'b0;
      mode_act_q  <= 1'b0;
      uo_q        <= 8'h00;
      uio_q       <= 8'h30;
      oe_q        <= 8'hFF;
    end else begin
      r_q         <= r_d;
      g_q         <= g_d;
      b_q         <= b_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      de_q        <= de_d;
      col_q       <= col_d;
      row_q       <= row_d;
      frm_q       <= frm_d;
      mode_meta_q <= mode_meta_d;
      mode_sync_q <= mode_sync_d;
      mode_act_q  <= mode_act_d;
      uo_q        <= uo_d;
      uio_q       <= uio_d;
      oe_q        <= oe_d;
    end
  end

  assign uo_out  = uo_q;
  assign uio_out = uio_q;
  assign uio_oe  = oe_q;

endmodule

// File: tb/tb_vga_pmod_out.sv
// tb/tb_vga_pmod_out.sv - scoreboard bench for vga_pmod_out (dithered and truncating instances).
module tb_vga_pmod_out;
  localparam int IB = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [IB-1:0] r_in = '0, g_in = '0, b_in = '0;
  logic          hs_in = 1'b1, vs_in = 1'b1, de_in = 1'b0, mode_sel = 1'b0;
  logic [7:0]    uo_d1, uio_d1, oe_d1, uo_t0, uio_t0, oe_t0;

  always #5 clk = ~clk;

  vga_pmod_out #(.IN_BITS(IB), .DITHER(1)) dut_dith (
    .clk(clk), .rst_n(rst_n), .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .hs_in(hs_in), .vs_in(vs_in), .de_in(de_in), .mode_sel(mode_sel),
    .uo_out(uo_d1), .uio_out(uio_d1), .uio_oe(oe_d1));

  vga_pmod_out #(.IN_BITS(IB), .DITHER(0)) dut_trunc (
    .clk(clk), .rst_n(rst_n), .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .hs_in(hs_in), .vs_in(vs_in), .de_in(de_in), .mode_sel(mode_sel),
    .uo_out(uo_t0), .uio_out(uio_t0), .uio_oe(oe_t0));

  typedef struct packed {
    logic [7:0] uo1, uio1, oe1, uo0, uio0, oe0;
  } exp_t;

  localparam exp_t RESET_EXP = '{8'h00, 8'h30, 8'hFF, 8'h00, 8'h30, 8'hFF};

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   in_reset = 1'b1;
  logic cur_ms = 1'b0;

  int bayer_tab [4][4] = '{'{0, 8, 2, 10}, '{12, 4, 14, 6}, '{3, 11, 1, 9}, '{15, 7, 13, 5}};

  // Reference state: pixel index in line, line index in frame, frame count, committed mode.
  bit m_prev_de, m_prev_vs, m_mode, m_ms_a, m_ms_b;
  int m_x, m_y, m_frm;

  function automatic int ref_chan(int v, int w, int t, bit dith);
    int n = IB - w;
    int q = v >> n;
    int rem = v % (1 << n);
    int fr = (n >= 4) ? (rem >> (n - 4)) : (rem << (4 - n));
    if (dith && fr > t && q < (1 << w) - 1) q = q + 1;
    return q;
  endfunction

  function automatic logic [23:0] ref_pins(bit mode, bit dith);
    int         w = mode ? 2 : 4;
    int         t = bayer_tab[m_y % 4][(m_x + m_frm) % 4];
    logic [3:0] rr, gg, bb;
    logic [7:0] uo, uio, oe;
    rr = de_in ? 4'(ref_chan(int'(r_in), w, t, dith)) : 4'd0;
    gg = de_in ? 4'(ref_chan(int'(g_in), w, t, dith)) : 4'd0;
    bb = de_in ? 4'(ref_chan(int'(b_in), w, t, dith)) : 4'd0;
    if (mode) begin
      uo  = {hs_in, bb[0], gg[0], rr[0], vs_in, bb[1], gg[1], rr[1]};
      uio = 8'h00;
      oe  = 8'h00;
    end else begin
      uo  = {bb, rr};
      uio = {2'b00, vs_in, hs_in, gg};
      oe  = 8'hFF;
    end
    return {uo, uio, oe};
  endfunction

  task automatic model_reset();
    m_prev_de = 1'b0; m_prev_vs = 1'b1; m_mode = 1'b0; m_ms_a = 1'b0; m_ms_b = 1'b0;
    m_x = 0; m_y = 0; m_frm = 0;
  endtask

  task automatic model_step();
    bit   vs_fall = !vs_in && m_prev_vs;
    bit   de_fall = !de_in && m_prev_de;
    exp_t e;
    m_x = (de_in && m_prev_de) ? m_x + 1 : 0;
    if (!vs_in) m_y = 0;
    else if (de_fall) m_y = m_y + 1;
    if (vs_fall) begin
      m_frm  = m_frm + 1;
      m_mode = m_ms_b;
    end
    m_ms_b = m_ms_a;
    m_ms_a = mode_sel;
    e = {ref_pins(m_mode, 1'b1), ref_pins(m_mode, 1'b0)};
    exp_q.push_back(e);
    m_prev_de = de_in;
    m_prev_vs = vs_in;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s cycle %0d got %h expected %h", name, cyc, act, expv);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (!in_reset && exp_q.size() == 3) begin
      mon_e = exp_q.pop_front();
      check("uo_dith", uo_d1, mon_e.uo1);
      check("uio_dith", uio_d1, mon_e.uio1);
      check("oe_dith", oe_d1, mon_e.oe1);
      check("uo_trunc", uo_t0, mon_e.uo0);
      check("uio_trunc", uio_t0, mon_e.uio0);
      check("oe_trunc", oe_t0, mon_e.oe0);
    end
  end

  function automatic logic [IB-1:0] rand_col();
    case ($urandom_range(0, 3))
      0: return '1;
      1: return 6'b011000;
      2: return 6'b101101;
      default: return IB'($urandom);
    endcase
  endfunction

  task automatic drive(input logic [IB-1:0] r, g, b, input logic h, v, d);
    @(posedge clk);
    #1;
    r_in = r; g_in = g; b_in = b;
    hs_in = h; vs_in = v; de_in = d;
    mode_sel = cur_ms;
    model_step();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    in_reset = 1'b1;
    #1;
    check("rst_uo_dith", uo_d1, 8'h00);
    check("rst_uio_dith", uio_d1, 8'h30);
    check("rst_oe_dith", oe_d1, 8'hFF);
    check("rst_uo_trunc", uo_t0, 8'h00);
    check("rst_uio_trunc", uio_t0, 8'h30);
    check("rst_oe_trunc", oe_t0, 8'hFF);
    hs_in = 1'b1; vs_in = 1'b1; de_in = 1'b0;
    r_in = '0; g_in = '0; b_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    model_reset();
    exp_q.delete();
    exp_q.push_back(RESET_EXP);
    model_step();
    in_reset = 1'b0;
  endtask

  task automatic run_line(input int len, input bit end_on_pixel);
    repeat (2) drive(rand_col(), rand_col(), rand_col(), 1'b0, 1'b1, 1'b0);
    drive(rand_col(), rand_col(), rand_col(), 1'b1, 1'b1, 1'b0);
    for (int p = 0; p < len; p++) begin
      int ev = $urandom_range(0, 9);
      if (ev <= 1) cur_ms = ~cur_ms;
      drive(rand_col(), rand_col(), rand_col(), 1'b1, 1'b1, 1'b1);
      if (ev == 1) cur_ms = ~cur_ms;
    end
    if (!end_on_pixel) drive(rand_col(), rand_col(), rand_col(), 1'b1, 1'b1, 1'b0);
  endtask

  // simul: vsync falls in the cycle right after the last pixel of the frame.
  task automatic run_frame(input int lines, input bit new_mode, input bit simul);
    for (int l = 0; l < lines; l++) begin
      if (l == lines - 1) cur_ms = new_mode;
      run_line((l == 0) ? 5 : $urandom_range(1, 9), simul && (l == lines - 1));
    end
    if (!simul) begin
      cur_ms = new_mode;
      repeat (2) drive(rand_col(), rand_col(), rand_col(), 1'b1, 1'b1, 1'b0);
    end
    repeat (3) drive(rand_col(), rand_col(), rand_col(), 1'b1, 1'b0, 1'b0);
    drive(rand_col(), rand_col(), rand_col(), 1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    do_reset();
    run_frame(5, 1'b0, 1'b0);
    run_frame(5, 1'b1, 1'b0);
    run_frame(4, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++)
      run_frame($urandom_range(1, 6), 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0));
    cur_ms = 1'b1;
    run_line(3, 1'b1);
    do_reset();
    run_frame(2, 1'b1, 1'b0);
    run_frame(3, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++)
      run_frame($urandom_range(1, 6), 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0));
    repeat (4) drive('0, '0, '0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
